// File: rtl/state_sequencer.sv
// state_sequencer: walks a fixed 11-state graph (0..10), one transition per clock.
// Branch decisions come from br_req / retry_req / abort_req sampled in the current state.
// Tracks a bounded 8<->9 retry loop (retry_cnt) and completed 7->0 passes (pass_cnt).
// Optional feature macro: SEQ_ILLEGAL_TRAP_EN -- when defined, entering an illegal
// state (11..15) sets a sticky err flag and clears retry_cnt; when undefined err is 0.
module state_sequencer #(
  parameter int STATE_W   = 4,
  parameter int RETRY_MAX = 3,
  parameter int CNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         br_req,
  input  logic               retry_req,
  input  logic               abort_req,
  output logic [STATE_W-1:0] state,
  output logic               state_vld,
  output logic [3:0]         retry_cnt,
  output logic [CNT_W-1:0]   pass_cnt,
  output logic               err
);

  typedef enum logic [3:0] {
    ST_0  = 4'd0,
    ST_1  = 4'd1,
    ST_2  = 4'd2,
    ST_3  = 4'd3,
    ST_4  = 4'd4,
    ST_5  = 4'd5,
    ST_6  = 4'd6,
    ST_7  = 4'd7,
    ST_8  = 4'd8,
    ST_9  = 4'd9,
    ST_10 = 4'd10
  } state_e;

  logic [STATE_W-1:0] state_q;
  state_e             cur_state;
  state_e             next_state;
  logic               legal;
  logic [3:0]         retry_nxt;
  logic               pass_inc;

  assign state     = state_q;
  assign cur_state = state_e'(state_q[3:0]);
  assign legal     = (state_q < STATE_W'(11));

  // Next-state, retry counter update and pass strobe from current state plus requests.
  // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latch).
  always_comb begin
    next_state = ST_0;
    retry_nxt  = retry_cnt;
    pass_inc   = 1'b0;
    if (legal) begin
      case (cur_state)
        ST_0:  next_state = ST_1;
        ST_1:  next_state = br_req[0] ? ST_4 : ST_2;
        ST_2:  next_state = ST_3;
        ST_3:  next_state = br_req[1] ? ST_1 : ST_5;
        ST_4:  next_state = ST_5;
        ST_5:  next_state = br_req[2] ? ST_6 : ST_1;
        ST_6:  next_state = ST_7;
        ST_7: begin
          if (br_req[3]) begin
            next_state = ST_8;
          end else begin
            next_state = ST_0;
            pass_inc   = 1'b1;
          end
        end
        ST_8: begin
          if (abort_req) begin
            next_state = ST_10;
            retry_nxt  = '0;
          end else if (retry_req && (retry_cnt < 4'(RETRY_MAX))) begin
            next_state = ST_9;
            retry_nxt  = retry_cnt + 4'd1;
          end else if (br_req[0]) begin
            next_state = ST_4;
            retry_nxt  = '0;
          end else begin
            next_state = ST_2;
            retry_nxt  = '0;
          end
        end
        // The loop stays bounded because 9->8 keeps the retry count.
        ST_9:    next_state = ST_8;
        ST_10:   next_state = ST_0;
        default: next_state = ST_0;
      endcase
    end
`ifdef SEQ_ILLEGAL_TRAP_EN
    if (!legal) begin
      retry_nxt = '0;
    end
`endif
  end

  // State, validity and counter registers.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= '0;
      state_vld <= 1'b0;
      retry_cnt <= '0;
      pass_cnt  <= '0;
    end else begin
      state_q   <= STATE_W'(next_state);
      state_vld <= 1'b1;
      retry_cnt <= retry_nxt;
      if (pass_inc) begin
        pass_cnt <= pass_cnt + CNT_W'(1);
      end
    end
  end

`ifdef SEQ_ILLEGAL_TRAP_EN
  // Sticky illegal-state flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (!legal) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_state_sequencer.sv
// Directed self-checking bench for state_sequencer (default parameters).
module tb_state_sequencer;

  localparam int STATE_W   = 4;
  localparam int RETRY_MAX = 3;
  localparam int CNT_W     = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [3:0]         br_req = '0;
  logic               retry_req = 1'b0;
  logic               abort_req = 1'b0;
  logic [STATE_W-1:0] state;
  logic               state_vld;
  logic [3:0]         retry_cnt;
  logic [CNT_W-1:0]   pass_cnt;
  logic               err;

  int checks = 0;
  int passes = 0;

  state_sequencer #(
    .STATE_W  (STATE_W),
    .RETRY_MAX(RETRY_MAX),
    .CNT_W    (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .br_req   (br_req),
    .retry_req(retry_req),
    .abort_req(abort_req),
    .state    (state),
    .state_vld(state_vld),
    .retry_cnt(retry_cnt),
    .pass_cnt (pass_cnt),
    .err      (err)
  );

  always #5 clk = ~clk;

  // One clock edge, then settle 1 time unit so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Synchronous-looking reset pulse; leaves state=0 with rst low, next edge goes 0->1.
  task automatic do_reset();
    br_req    = '0;
    retry_req = 1'b0;
    abort_req = 1'b0;
    rst       = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    checks++; if (state !== 4'd0) $display("FAIL reset_state got %0d want 0", state); else passes++;
    checks++; if (state_vld !== 1'b0) $display("FAIL reset_vld got %0b want 0", state_vld); else passes++;
    checks++; if (retry_cnt !== 4'd0) $display("FAIL reset_retry got %0d want 0", retry_cnt); else passes++;
    checks++; if (pass_cnt !== 8'd0) $display("FAIL reset_pass got %0d want 0", pass_cnt); else passes++;
    checks++; if (err !== 1'b0) $display("FAIL reset_err got %0b want 0", err); else passes++;
    rst = 1'b0;
    step();
    checks++; if (state_vld !== 1'b1) $display("FAIL reset_vld_after got %0b want 1", state_vld); else passes++;
    checks++; if (state !== 4'd1) $display("FAIL reset_first_state got %0d want 1", state); else passes++;
  endtask

  task automatic test_default_loop();
    logic [3:0] exp_s [8];
    exp_s = '{4'd1, 4'd2, 4'd3, 4'd5, 4'd1, 4'd2, 4'd3, 4'd5};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (state !== exp_s[i]) $display("FAIL loop_state[%0d] got %0d want %0d", i, state, exp_s[i]);
      else passes++;
    end
    checks++; if (pass_cnt !== 8'd0) $display("FAIL loop_pass got %0d want 0", pass_cnt); else passes++;
  endtask

  task automatic test_full_pass();
    logic [3:0] exp_s [6];
    exp_s = '{4'd1, 4'd4, 4'd5, 4'd6, 4'd7, 4'd0};
    do_reset();
    br_req = 4'b0101;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (state !== exp_s[i]) $display("FAIL pass_state[%0d] got %0d want %0d", i, state, exp_s[i]);
      else passes++;
      if (i == 4) begin
        checks++; if (pass_cnt !== 8'd0) $display("FAIL pass_cnt_before got %0d want 0", pass_cnt); else passes++;
      end
    end
    checks++; if (pass_cnt !== 8'd1) $display("FAIL pass_cnt_after got %0d want 1", pass_cnt); else passes++;
  endtask

  task automatic test_branches();
    logic [3:0] exp_a [6];
    logic [3:0] exp_b [6];
    exp_a = '{4'd1, 4'd2, 4'd3, 4'd1, 4'd2, 4'd3};
    exp_b = '{4'd5, 4'd6, 4'd7, 4'd8, 4'd4, 4'd5};
    do_reset();
    br_req = 4'b0010;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (state !== exp_a[i]) $display("FAIL br1_state[%0d] got %0d want %0d", i, state, exp_a[i]);
      else passes++;
    end
    br_req = 4'b1101;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (state !== exp_b[i]) $display("FAIL br2_state[%0d] got %0d want %0d", i, state, exp_b[i]);
      else passes++;
    end
    checks++; if (retry_cnt !== 4'd0) $display("FAIL br2_retry got %0d want 0", retry_cnt); else passes++;
  endtask

  task automatic test_retry_loop();
    logic [3:0] exp_s [7];
    logic [3:0] exp_r [7];
    exp_s = '{4'd9, 4'd8, 4'd9, 4'd8, 4'd9, 4'd8, 4'd2};
    exp_r = '{4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3, 4'd0};
    do_reset();
    br_req = 4'b1101;
    for (int i = 0; i < 6; i++) step();
    checks++; if (state !== 4'd8) $display("FAIL retry_reach8 got %0d want 8", state); else passes++;
    br_req    = 4'b0000;
    retry_req = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      checks++;
      if (state !== exp_s[i]) $display("FAIL retry_state[%0d] got %0d want %0d", i, state, exp_s[i]);
      else passes++;
      checks++;
      if (retry_cnt !== exp_r[i]) $display("FAIL retry_cnt[%0d] got %0d want %0d", i, retry_cnt, exp_r[i]);
      else passes++;
    end
    retry_req = 1'b0;
  endtask

  task automatic test_abort();
    do_reset();
    br_req = 4'b0101;
    for (int i = 0; i < 6; i++) step();
    br_req = 4'b1101;
    for (int i = 0; i < 6; i++) step();
    checks++; if (state !== 4'd8) $display("FAIL abort_reach8 got %0d want 8", state); else passes++;
    br_req    = 4'b0000;
    retry_req = 1'b1;
    step();
    checks++; if (retry_cnt !== 4'd1) $display("FAIL abort_pre_retry got %0d want 1", retry_cnt); else passes++;
    abort_req = 1'b1;
    step();
    checks++; if (state !== 4'd8) $display("FAIL abort_9to8 got %0d want 8", state); else passes++;
    checks++; if (retry_cnt !== 4'd1) $display("FAIL abort_hold_retry got %0d want 1", retry_cnt); else passes++;
    step();
    checks++; if (state !== 4'd10) $display("FAIL abort_state got %0d want 10", state); else passes++;
    checks++; if (retry_cnt !== 4'd0) $display("FAIL abort_retry_clr got %0d want 0", retry_cnt); else passes++;
    abort_req = 1'b0;
    retry_req = 1'b0;
    step();
    checks++; if (state !== 4'd0) $display("FAIL abort_to0 got %0d want 0", state); else passes++;
    checks++; if (pass_cnt !== 8'd1) $display("FAIL abort_pass got %0d want 1", pass_cnt); else passes++;
    step();
    checks++; if (state !== 4'd1) $display("FAIL abort_restart got %0d want 1", state); else passes++;
  endtask

  task automatic test_async_reset();
    do_reset();
    br_req = 4'b0101;
    for (int i = 0; i < 6; i++) step();
    for (int i = 0; i < 4; i++) step();
    checks++; if (state !== 4'd6) $display("FAIL arst_reach6 got %0d want 6", state); else passes++;
    #2;
    rst = 1'b1;
    #1;
    checks++; if (state !== 4'd0) $display("FAIL arst_state got %0d want 0", state); else passes++;
    checks++; if (pass_cnt !== 8'd0) $display("FAIL arst_pass got %0d want 0", pass_cnt); else passes++;
    checks++; if (state_vld !== 1'b0) $display("FAIL arst_vld got %0b want 0", state_vld); else passes++;
    checks++; if (retry_cnt !== 4'd0) $display("FAIL arst_retry got %0d want 0", retry_cnt); else passes++;
    @(negedge clk);
    rst = 1'b0;
    step();
    checks++; if (state !== 4'd1) $display("FAIL arst_restart got %0d want 1", state); else passes++;
    checks++; if (state_vld !== 1'b1) $display("FAIL arst_vld_after got %0b want 1", state_vld); else passes++;
  endtask

  task automatic test_pass_wrap();
    do_reset();
    br_req = 4'b0101;
    for (int p = 0; p < 255; p++) begin
      for (int i = 0; i < 6; i++) step();
    end
    checks++; if (pass_cnt !== 8'd255) $display("FAIL wrap_pre got %0d want 255", pass_cnt); else passes++;
    for (int i = 0; i < 6; i++) step();
    checks++; if (pass_cnt !== 8'd0) $display("FAIL wrap_post got %0d want 0", pass_cnt); else passes++;
    checks++; if (state !== 4'd0) $display("FAIL wrap_state got %0d want 0", state); else passes++;
  endtask

  task automatic test_illegal();
    do_reset();
    br_req = 4'b1101;
    for (int i = 0; i < 6; i++) step();
    br_req    = 4'b0000;
    retry_req = 1'b1;
    step();
    retry_req = 1'b0;
    checks++; if (retry_cnt !== 4'd1) $display("FAIL ill_pre_retry got %0d want 1", retry_cnt); else passes++;
    force dut.state_q = 4'd12;
    #1;
    release dut.state_q;
    step();
    checks++; if (state !== 4'd0) $display("FAIL ill_state got %0d want 0", state); else passes++;
`ifdef SEQ_ILLEGAL_TRAP_EN
    checks++; if (err !== 1'b1) $display("FAIL ill_err got %0b want 1", err); else passes++;
    checks++; if (retry_cnt !== 4'd0) $display("FAIL ill_retry got %0d want 0", retry_cnt); else passes++;
`else
    checks++; if (err !== 1'b0) $display("FAIL ill_err got %0b want 0", err); else passes++;
    checks++; if (retry_cnt !== 4'd1) $display("FAIL ill_retry got %0d want 1", retry_cnt); else passes++;
`endif
    step();
    checks++; if (state !== 4'd1) $display("FAIL ill_next got %0d want 1", state); else passes++;
`ifdef SEQ_ILLEGAL_TRAP_EN
    checks++; if (err !== 1'b1) $display("FAIL ill_err_sticky got %0b want 1", err); else passes++;
`else
    checks++; if (err !== 1'b0) $display("FAIL ill_err_sticky got %0b want 0", err); else passes++;
`endif
    do_reset();
    checks++; if (err !== 1'b0) $display("FAIL ill_err_rst got %0b want 0", err); else passes++;
  endtask

  initial begin
    test_reset();
    test_default_loop();
    test_full_pass();
    test_branches();
    test_retry_loop();
    test_abort();
    test_async_reset();
    test_pass_wrap();
    test_illegal();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
